// File: rtl/game_core.sv
// HEROE gameplay engine: scrolls LFSR-spawned obstacles toward the hero digit, handles jumps,
// scores cleared obstacles and reports win/lose. Optional macro GAME_SPEEDUP_EN halves the tick period late in a run.
module game_core #(
    parameter int          TICK_DIV   = 25_000_000,
    parameter int          JUMP_TICKS = 2,
    parameter int          WIN_SCORE  = 10,
    parameter logic [2:0]  PLAY_STATE = 3'd2,
    parameter logic [4:0]  JUMP_KEY   = 5'd10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  presente,
    input  logic [4:0]  key,
    input  logic        keypad_pressed,
    output logic [1:0]  W_or_L,
    output logic [3:0]  score,
    output logic [27:0] display_game
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int JMP_W = ($clog2(JUMP_TICKS + 1) > 0) ? $clog2(JUMP_TICKS + 1) : 1;

    localparam logic [7:0]       LFSR_SEED = 8'hA5;
    localparam logic [CNT_W-1:0] LAST_SLOW = CNT_W'(TICK_DIV - 1);
    localparam logic [JMP_W-1:0] JUMP_LOAD = JMP_W'(JUMP_TICKS);
    localparam logic [3:0]       WIN_Q     = 4'(WIN_SCORE);
`ifdef GAME_SPEEDUP_EN
    localparam logic [CNT_W-1:0] LAST_FAST = CNT_W'((TICK_DIV / 2 > 0) ? (TICK_DIV / 2 - 1) : 0);
    localparam logic [3:0]       HALF_Q    = 4'(WIN_SCORE / 2);
`endif

    localparam logic [6:0] SEG_OBST   = 7'b0010100;
    localparam logic [6:0] SEG_GROUND = 7'b0001000;
    localparam logic [6:0] SEG_AIR    = 7'b0000001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WON  = 2'd2,
        S_LOST = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        occ_q, occ_d;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [JMP_W-1:0]  jump_cnt_q, jump_cnt_d;
    logic [3:0]        score_q, score_d;
    logic              kp_q, kp_d;

    logic              in_play;
    logic [CNT_W-1:0]  cnt_last;
    logic              tick;
    logic              press_edge;
    logic              lose_hit;
    logic              win_hit;
    logic              decide;
    logic              spawn;
    logic [3:0]        score_next;
    logic [7:0]        lfsr_step;
    logic [6:0]        hero_seg;

`ifdef GAME_SPEEDUP_EN
    // Score only changes at a wrap, so the shorter period takes effect from the following wrap.
    assign cnt_last = (score_q >= HALF_Q) ? LAST_FAST : LAST_SLOW;
`else
    assign cnt_last = LAST_SLOW;
`endif

    assign in_play    = (presente == PLAY_STATE);
    assign tick       = (state_q == S_RUN) && (cnt_q >= cnt_last);
    assign press_edge = keypad_pressed && !kp_q && (key == JUMP_KEY);
    assign lose_hit   = occ_q[1] && (jump_cnt_q == '0);
    assign score_next = (occ_q[0] && (score_q < WIN_Q)) ? (score_q + 4'd1) : score_q;
    assign win_hit    = occ_q[0] && (score_next == WIN_Q);
    assign decide     = tick && (lose_hit || win_hit);
    assign spawn      = (lfsr_q[1:0] == 2'b00) && !occ_q[3] && !occ_q[2];
    assign lfsr_step  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; losing wins the tie against winning on the same tick
    always_comb begin
        state_d = state_q;
        if (!in_play) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_RUN;
                S_RUN: begin
                    if (tick && lose_hit) begin
                        state_d = S_LOST;
                    end else if (tick && win_hit) begin
                        state_d = S_WON;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            occ_q      <= '0;
            lfsr_q     <= LFSR_SEED;
            jump_cnt_q <= '0;
            score_q    <= '0;
            kp_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            occ_q      <= occ_d;
            lfsr_q     <= lfsr_d;
            jump_cnt_q <= jump_cnt_d;
            score_q    <= score_d;
            kp_q       <= kp_d;
        end
    end

    // The deciding tick leaves track, LFSR and jump untouched so the frame freezes as last shown in RUN.
    always_comb begin
        cnt_d      = cnt_q;
        occ_d      = occ_q;
        lfsr_d     = lfsr_q;
        jump_cnt_d = jump_cnt_q;
        score_d    = score_q;
        kp_d       = keypad_pressed;

        if (!in_play || (state_q == S_IDLE)) begin
            cnt_d      = '0;
            occ_d      = '0;
            lfsr_d     = LFSR_SEED;
            jump_cnt_d = '0;
            score_d    = '0;
        end else if (state_q == S_RUN) begin
            cnt_d = tick ? '0 : (cnt_q + 1'b1);
            if (tick) begin
                score_d = score_next;
                if (!decide) begin
                    occ_d  = {spawn, occ_q[3:1]};
                    lfsr_d = lfsr_step;
                    if (jump_cnt_q != '0) begin
                        jump_cnt_d = jump_cnt_q - 1'b1;
                    end
                end
            end
            if (press_edge && (jump_cnt_q == '0) && !decide) begin
                jump_cnt_d = JUMP_LOAD;
            end
        end
    end

    // Outputs
    always_comb begin
        W_or_L       = 2'b00;
        display_game = '0;
        hero_seg     = (jump_cnt_q != '0) ? SEG_AIR : SEG_GROUND;
        case (state_q)
            S_WON:   W_or_L = 2'b01;
            S_LOST:  W_or_L = 2'b10;
            default: W_or_L = 2'b00;
        endcase
        if (state_q != S_IDLE) begin
            display_game = {occ_q[3] ? SEG_OBST : 7'b0,
                            occ_q[2] ? SEG_OBST : 7'b0,
                            occ_q[1] ? SEG_OBST : 7'b0,
                            (occ_q[0] ? SEG_OBST : 7'b0) | hero_seg};
        end
    end

    assign score = score_q;

endmodule
